// File: rtl/uart_pkg.sv
// Shared types and parity helper for the multi-format UART transmitter.
package uart_pkg;

  localparam int unsigned MaxDataWidth = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  typedef struct packed {
    logic par_en;
    logic par_typ;
    logic stop2;
  } tx_cfg_t;

  // Data narrower than MaxDataWidth is zero-extended by the caller; parity is unaffected.
  function automatic logic calc_parity(input logic [MaxDataWidth-1:0] data,
                                       input logic                    par_typ);
    return (^data) ^ par_typ;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words (with their frame config) ahead of the UART shifter.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PtrW + 1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the cleared count makes stale entries unreachable.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_tx_multi.sv
// UART transmitter: runtime prescaler, per-word parity/stop config, buffered input.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry input FIFO; otherwise a single holding register.
module uart_tx_multi
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_valid,
  output logic                      Data_ready,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      busy
);

  localparam int unsigned EntryW  = DATA_WIDTH + 3;
  localparam int unsigned BitCntW = $clog2(DATA_WIDTH);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > MaxDataWidth || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_multi: illegal DATA_WIDTH or FIFO_DEPTH");
  end

  tx_cfg_t                   w_in_cfg;
  logic [EntryW-1:0]         w_in_entry;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_buf_valid;
  logic [EntryW-1:0]         w_buf_entry;
  tx_cfg_t                   w_buf_cfg;
  logic [DATA_WIDTH-1:0]     w_buf_data;
  logic [MaxDataWidth-1:0]   w_par_ext;
  logic [PRESCALE_WIDTH-1:0] w_presc_m1;
  logic                      w_tick;
  logic                      w_frame_end;

  tx_state_e                 r_state;
  tx_cfg_t                   r_cfg;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic                      r_par_bit;
  logic [PRESCALE_WIDTH-1:0] r_presc_m1;
  logic [PRESCALE_WIDTH-1:0] r_div;
  logic [BitCntW-1:0]        r_bit_cnt;
  logic                      r_stop_cnt;
  logic                      r_tx;
  logic                      r_busy;

  always_comb begin
    w_in_cfg         = '0;
    w_in_cfg.par_en  = PAR_EN;
    w_in_cfg.par_typ = PAR_TYP;
    w_in_cfg.stop2   = STOP2;
  end

  assign w_in_entry = {w_in_cfg, P_DATA};
  assign w_push     = Data_valid && Data_ready;

`ifdef UART_TX_FIFO_EN
  logic w_full;
  logic w_empty;

  uart_tx_fifo #(
    .WIDTH (EntryW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_data  (w_in_entry),
    .i_pop   (w_pop),
    .o_data  (w_buf_entry),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign Data_ready  = !w_full;
  assign w_buf_valid = !w_empty;
`else
  logic              r_hold_valid;
  logic [EntryW-1:0] r_hold_entry;

  // Push needs an empty holder and pop a full one, so they never coincide.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hold_valid <= 1'b0;
      r_hold_entry <= '0;
    end else if (w_push) begin
      r_hold_valid <= 1'b1;
      r_hold_entry <= w_in_entry;
    end else if (w_pop) begin
      r_hold_valid <= 1'b0;
    end
  end

  assign Data_ready  = !r_hold_valid;
  assign w_buf_valid = r_hold_valid;
  assign w_buf_entry = r_hold_entry;
`endif

  assign w_buf_cfg  = tx_cfg_t'(w_buf_entry[EntryW-1 -: 3]);
  assign w_buf_data = w_buf_entry[DATA_WIDTH-1:0];

  always_comb begin
    w_par_ext                 = '0;
    w_par_ext[DATA_WIDTH-1:0] = w_buf_data;
  end

  assign w_presc_m1  = (PRESCALE == '0) ? '0 : PRESCALE - PRESCALE_WIDTH'(1);
  assign w_tick      = (r_div == r_presc_m1);
  assign w_frame_end = (r_state == STOP) && w_tick && (!r_cfg.stop2 || r_stop_cnt);
  // Loading from IDLE or straight out of the last stop bit keeps frames back-to-back.
  assign w_pop       = w_buf_valid && ((r_state == IDLE) || w_frame_end);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_cfg      <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_presc_m1 <= '0;
      r_div      <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else if (w_pop) begin
      r_state    <= START;
      r_cfg      <= w_buf_cfg;
      r_shift    <= w_buf_data;
      r_par_bit  <= calc_parity(w_par_ext, w_buf_cfg.par_typ);
      r_presc_m1 <= w_presc_m1;
      r_div      <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      if (r_state != IDLE) r_div <= w_tick ? '0 : r_div + PRESCALE_WIDTH'(1);
      unique case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_cnt == LastBit) begin
              r_state    <= r_cfg.par_en ? PARITY : STOP;
              r_tx       <= r_cfg.par_en ? r_par_bit : 1'b1;
              r_stop_cnt <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_state    <= STOP;
            r_tx       <= 1'b1;
            r_stop_cnt <= 1'b0;
          end
        end
        STOP: begin
          if (w_frame_end) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
          end else if (w_tick) begin
            r_stop_cnt <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign TX_OUT = r_tx;
  assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_multi.sv
// Scoreboard bench for uart_tx_multi: frames decoded from TX_OUT against a bit-list model.
`timescale 1ns/1ps
module tb_uart_tx_multi;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 8;
  localparam int unsigned FD = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_valid;
  logic          Data_ready;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          STOP2;
  logic [PW-1:0] PRESCALE;
  logic          TX_OUT;
  logic          busy;

  always #5 CLK = ~CLK;

  uart_tx_multi #(
    .DATA_WIDTH     (DW),
    .PRESCALE_WIDTH (PW),
    .FIFO_DEPTH     (FD)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_valid (Data_valid),
    .Data_ready (Data_ready),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .PRESCALE   (PRESCALE),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          pe;
    logic          pt;
    logic          s2;
    int            acc;
  } word_t;

  word_t   sb[$];
  int      starts[$];
  int      n_tests = 0;
  int      n_fail = 0;
  int      n_sent = 0;
  int      frames_done = 0;
  int      cyc = 0;
  int      busy_cnt = 0;
  int      stall_cnt = 0;
  logic [PW-1:0] ps_at_edge = '0;

  always @(posedge CLK) begin
    cyc        <= cyc + 1;
    ps_at_edge <= PRESCALE;
  end

  always @(negedge CLK) begin
    if (busy === 1'b1) busy_cnt = busy_cnt + 1;
    if (Data_valid === 1'b1 && Data_ready === 1'b0) stall_cnt = stall_cnt + 1;
  end

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: on each start bit pop the oldest accepted word and expect its waveform.
  logic  mon_active = 1'b0;
  logic  after_frame = 1'b0;
  logic  skip_low = 1'b0;
  logic  exp_wave[$];
  logic  bits[$];
  word_t cur;
  int    p;
  int    samp_idx;
  int    bad_idx;
  logic  bad_tx;
  logic  bad_busy;
  logic  bad_exp;
  logic  e;

  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      mon_active  = 1'b0;
      after_frame = 1'b0;
      skip_low    = 1'b0;
      exp_wave.delete();
      sb.delete();
    end else begin
      if (skip_low && TX_OUT === 1'b1) skip_low = 1'b0;
      if (!mon_active && !skip_low && TX_OUT === 1'b0) begin
        after_frame = 1'b0;
        check_eq("frame_expected", longint'(sb.size() > 0), 1);
        if (sb.size() == 0) begin
          skip_low = 1'b1;
        end else begin
          cur = sb.pop_front();
          p   = (ps_at_edge == '0) ? 1 : int'(ps_at_edge);
          bits.delete();
          bits.push_back(1'b0);
          for (int i = 0; i < DW; i++) bits.push_back(cur.data[i]);
          if (cur.pe) bits.push_back((($countones(cur.data) % 2) == 1) ^ cur.pt);
          bits.push_back(1'b1);
          if (cur.s2) bits.push_back(1'b1);
          foreach (bits[k]) for (int r = 0; r < p; r++) exp_wave.push_back(bits[k]);
          starts.push_back(cyc);
          mon_active = 1'b1;
          samp_idx   = 0;
          bad_idx    = -1;
        end
      end else if (!mon_active && after_frame) begin
        check_eq("busy_low_after_frame", longint'(busy), 0);
        after_frame = 1'b0;
      end
      if (mon_active) begin
        e = exp_wave.pop_front();
        if (bad_idx < 0 && (TX_OUT !== e || busy !== 1'b1)) begin
          bad_idx  = samp_idx;
          bad_tx   = TX_OUT;
          bad_busy = busy;
          bad_exp  = e;
        end
        samp_idx++;
        if (exp_wave.size() == 0) begin
          n_tests++;
          frames_done++;
          if (bad_idx >= 0) begin
            n_fail++;
            $display("FAIL frame data=%h pe=%b pt=%b s2=%b P=%0d sample %0d: tx=%b busy=%b, expected tx=%b busy=1",
                     cur.data, cur.pe, cur.pt, cur.s2, p, bad_idx, bad_tx, bad_busy, bad_exp);
          end
          mon_active  = 1'b0;
          after_frame = 1'b1;
        end
      end
    end
  end

  // Called at a negedge; returns one negedge after the accepting posedge with Data_valid still high.
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt, input logic s2,
                      output int acc);
    word_t w;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    STOP2      = s2;
    Data_valid = 1'b1;
    for (int i = 0; i < 5000 && Data_ready !== 1'b1; i++) @(negedge CLK);
    check_eq("ready_within_bound", longint'(Data_ready === 1'b1), 1);
    acc = -1;
    if (Data_ready === 1'b1) begin
      acc    = cyc + 1;
      w.data = d;
      w.pe   = pe;
      w.pt   = pt;
      w.s2   = s2;
      w.acc  = acc;
      sb.push_back(w);
      n_sent++;
      @(negedge CLK);
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 20000; i++) begin
      if (sb.size() == 0 && !mon_active && !after_frame && busy === 1'b0) break;
      @(negedge CLK);
    end
    check_eq("idle_within_bound", longint'(i < 20000), 1);
  endtask

  int acc0;
  int acc1;
  int acc2;
  int base;
  int target;
  int gap;

  initial begin
    RST        = 1'b1;
    Data_valid = 1'b0;
    P_DATA     = '0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    STOP2      = 1'b0;
    PRESCALE   = PW'(1);
    repeat (2) @(negedge CLK);
    check_eq("reset_tx", longint'(TX_OUT), 1);
    check_eq("reset_busy", longint'(busy), 0);
    check_eq("reset_ready", longint'(Data_ready), 1);
    #2 RST = 1'b0;
    @(negedge CLK);

    // 1: 0x00, no parity, one stop, one bit per clock
    starts.delete();
    base = busy_cnt;
    send(8'h00, 1'b0, 1'b0, 1'b0, acc0);
    Data_valid = 1'b0;
    wait_idle();
    check_eq("t1_latency", longint'(starts[0] - acc0), 1);
    check_eq("t1_busy_cycles", longint'(busy_cnt - base), 10);

    // 2: 0x48 even then odd parity
    starts.delete();
    base = busy_cnt;
    send(8'h48, 1'b1, 1'b0, 1'b0, acc0);
    send(8'h48, 1'b1, 1'b1, 1'b0, acc1);
    Data_valid = 1'b0;
    wait_idle();
    check_eq("t2_frames", longint'(starts.size()), 2);
    if (starts.size() == 2) check_eq("t2_frame_len", longint'(starts[1] - starts[0]), 11);
    check_eq("t2_busy_cycles", longint'(busy_cnt - base), 22);

    // 3: PRESCALE=4, 0xA5, two stop bits
    PRESCALE = PW'(4);
    base     = busy_cnt;
    send(8'hA5, 1'b0, 1'b0, 1'b1, acc0);
    Data_valid = 1'b0;
    wait_idle();
    check_eq("t3_busy_cycles", longint'(busy_cnt - base), 44);

    // 4: valid held over six words
    PRESCALE = PW'(1);
    starts.delete();
    base = stall_cnt;
    for (int k = 0; k < 6; k++) send(8'h11 + DW'(k), 1'b0, 1'b0, 1'b0, acc0);
    Data_valid = 1'b0;
    wait_idle();
    check_eq("t4_ready_fell", longint'((stall_cnt - base) > 0), 1);
    check_eq("t4_frames", longint'(starts.size()), 6);
    if (starts.size() == 6)
      for (int k = 0; k < 5; k++) check_eq("t4_back_to_back", longint'(starts[k+1] - starts[k]), 10);

    // 5: reset during data bit 3
    PRESCALE = PW'(2);
    send(8'h3C, 1'b0, 1'b0, 1'b0, acc0);
    Data_valid = 1'b0;
    target = acc0 + 1 + 2 * 4 + 1;
    for (int i = 0; i < 1000 && cyc < target; i++) @(negedge CLK);
    check_eq("t5_reach_bit3", longint'(cyc), longint'(target));
    check_eq("t5_busy_before_reset", longint'(busy), 1);
    #2 RST = 1'b1;
    #1;
    check_eq("t5_reset_tx", longint'(TX_OUT), 1);
    check_eq("t5_reset_busy", longint'(busy), 0);
    check_eq("t5_reset_ready", longint'(Data_ready), 1);
    @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    send(8'h5A, 1'b1, 1'b1, 1'b0, acc0);
    Data_valid = 1'b0;
    wait_idle();

    // 6: three words back-to-back
    PRESCALE = PW'(1);
    starts.delete();
    send(8'hC3, 1'b0, 1'b0, 1'b0, acc0);
    send(8'h7E, 1'b1, 1'b0, 1'b0, acc1);
    send(8'h81, 1'b0, 1'b0, 1'b1, acc2);
    Data_valid = 1'b0;
    wait_idle();
    check_eq("t6_frames", longint'(starts.size()), 3);
    if (starts.size() == 3) begin
      check_eq("t6_second_during_first", longint'(acc1 < starts[0] + 10), 1);
`ifdef UART_TX_FIFO_EN
      check_eq("t6_third_accept", longint'(acc2), longint'(acc1 + 1));
`else
      check_eq("t6_third_accept", longint'(acc2), longint'(starts[1] + 1));
`endif
    end

    // Randomised words; PRESCALE may change mid-frame
    for (int w = 0; w < 60; w++) begin
      if ($urandom_range(0, 7) == 0) PRESCALE = PW'($urandom_range(0, 4));
      send(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), acc0);
      gap = int'($urandom_range(0, 3));
      if (gap != 0) begin
        Data_valid = 1'b0;
        repeat (gap) @(negedge CLK);
      end
    end
    Data_valid = 1'b0;
    wait_idle();

    check_eq("frames_total", longint'(frames_done), longint'(n_sent - 1));
    check_eq("sb_drained", longint'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
